// File: rtl/ustc_psum_sched_if.sv
// Handshake and control bundle between the psum tile sequencer and its
// beat source / psum buffer.
interface ustc_psum_sched_if #(
  parameter int unsigned DW_COL  = 4,
  parameter int unsigned DW_BEAT = 8
);
  logic                 start;
  logic [DW_COL:0]      cfg_ncol;
  logic [DW_BEAT-1:0]   cfg_beats;
  logic                 in_valid;
  logic                 in_ready;
  logic [DW_COL-1:0]    col;
  logic                 wr_en;
  logic                 buf_rst;
  logic                 out_en;
  logic                 buf_valid;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  modport slave (
    input  start, cfg_ncol, cfg_beats, in_valid, buf_valid,
    output in_ready, col, wr_en, buf_rst, out_en, busy, done, cfg_err
  );

  modport master (
    output start, cfg_ncol, cfg_beats, in_valid, buf_valid,
    input  in_ready, col, wr_en, buf_rst, out_en, busy, done, cfg_err
  );
endinterface

// File: rtl/ustc_psum_sched.sv
// Tile sequencer for the unstructured psum column buffer: clears the buffer,
// fills it column by column, waits out the write pipe, then triggers and counts readout.
module ustc_psum_sched #(
  parameter int unsigned M        = 16,
  parameter int unsigned N        = 16,
  parameter int unsigned DW_COL   = 4,
  parameter int unsigned DW_BEAT  = 8,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  ustc_psum_sched_if.slave  bus
);
  localparam int unsigned RW = $clog2(M + 1);
  localparam int unsigned FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    FILL  = 3'd2,
    FLUSH = 3'd3,
    TRIG  = 3'd4,
    DRAIN = 3'd5
  } state_t;

  state_t               state;
  logic [DW_COL:0]      ncol_q;
  logic [DW_BEAT-1:0]   beats_q;
  logic [DW_BEAT-1:0]   beat_cnt;
  logic [DW_COL-1:0]    col_q;
  logic [RW-1:0]        row_cnt;
  logic [FW-1:0]        flush_cnt;
  logic                 in_ready_q;
  logic                 buf_rst_q;
  logic                 out_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic accept;
  logic cfg_ok;
  logic last_beat;
  logic last_col;

  assign accept    = bus.in_valid & in_ready_q;
  assign cfg_ok    = (bus.cfg_ncol != '0) && (bus.cfg_ncol <= (DW_COL+1)'(N)) &&
                     (bus.cfg_beats != '0);
  assign last_beat = (beat_cnt == beats_q - DW_BEAT'(1));
  assign last_col  = (({1'b0, col_q} + (DW_COL+1)'(1)) == ncol_q);

  assign bus.wr_en    = accept;
  assign bus.in_ready = in_ready_q;
  assign bus.col      = col_q;
  assign bus.buf_rst  = buf_rst_q;
  assign bus.out_en   = out_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cfg_err  = cfg_err_q;

  // Sequencer: pulse outputs default low each cycle and are raised on transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ncol_q     <= '0;
      beats_q    <= '0;
      beat_cnt   <= '0;
      col_q      <= '0;
      row_cnt    <= '0;
      flush_cnt  <= '0;
      in_ready_q <= 1'b0;
      buf_rst_q  <= 1'b1;
      out_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      buf_rst_q <= 1'b0;
      out_en_q  <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            if (cfg_ok) begin
              ncol_q    <= bus.cfg_ncol;
              beats_q   <= bus.cfg_beats;
              beat_cnt  <= '0;
              row_cnt   <= '0;
              flush_cnt <= '0;
              buf_rst_q <= 1'b1;
              busy_q    <= 1'b1;
              state     <= CLR;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        CLR: begin
          col_q      <= '0;
          in_ready_q <= 1'b1;
          state      <= FILL;
        end
        FILL: begin
          if (accept) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (last_col) begin
                in_ready_q <= 1'b0;
                flush_cnt  <= '0;
                state      <= FLUSH;
              end else begin
                col_q <= col_q + DW_COL'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + DW_BEAT'(1);
            end
          end
        end
        // Hold off readout until the last beat's buffer write has landed.
        FLUSH: begin
          if (flush_cnt == FW'(PIPE_LAT - 1)) begin
            out_en_q <= 1'b1;
            state    <= TRIG;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        TRIG: begin
          row_cnt <= '0;
          state   <= DRAIN;
        end
        DRAIN: begin
          if (bus.buf_valid) begin
            row_cnt <= row_cnt + RW'(1);
            if (row_cnt == RW'(M - 1)) begin
              done_q <= 1'b1;
              busy_q <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ustc_psum_sched.sv
// Randomized bench for ustc_psum_sched: predicts per-tile event timing
// (accept columns, readout trigger, drain completion) from the tile rules.
module tb_ustc_psum_sched;
  localparam int unsigned M        = 16;
  localparam int unsigned N        = 16;
  localparam int unsigned DW_COL   = 4;
  localparam int unsigned DW_BEAT  = 8;
  localparam int unsigned PIPE_LAT = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ustc_psum_sched_if #(.DW_COL(DW_COL), .DW_BEAT(DW_BEAT)) bus ();

  ustc_psum_sched #(
    .M(M), .N(N), .DW_COL(DW_COL), .DW_BEAT(DW_BEAT), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tile: stimulus modes select in_valid/buf_valid/start patterns; abort>0
  // stops the tile once that many rows have drained.
  task automatic run_tile(input int ncol, input int beats, input int vmode,
                          input int bmode, input int smode, input int abort,
                          output bit aborted);
    int   total, acc, last_acc, rows, done_cyc;
    bit   fin;
    logic exp_rdy, exp_oe, exp_done, exp_busy, exp_brst;
    logic [DW_COL-1:0] exp_col;
    total = ncol * beats; acc = 0; last_acc = -1; rows = 0; done_cyc = -1;
    fin = 1'b0; aborted = 1'b0;
    bus.start     = 1'b1;
    bus.cfg_ncol  = (DW_COL+1)'(ncol);
    bus.cfg_beats = DW_BEAT'(beats);
    bus.in_valid  = 1'b0;
    bus.buf_valid = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL pre_start_busy got=%b exp=0", bus.busy); end
    tick();
    for (int c = 1; c < 3000 && !fin && !aborted; c++) begin
      if (c == done_cyc || smode == 0) bus.start = 1'b0;
      else if (smode == 1)              bus.start = 1'($urandom);
      else                              bus.start = 1'b1;
      bus.cfg_ncol  = (DW_COL+1)'($urandom);
      bus.cfg_beats = DW_BEAT'($urandom);
      case (vmode)
        0:       bus.in_valid = 1'b1;
        1:       bus.in_valid = (c % 2 == 0);
        default: bus.in_valid = 1'($urandom);
      endcase
      bus.buf_valid = (bmode == 0) ? 1'b1 : 1'($urandom);
      #1;
      exp_rdy  = (c >= 2) && (acc < total);
      exp_oe   = (last_acc >= 0) && (c == last_acc + 1 + PIPE_LAT);
      exp_done = (c == done_cyc);
      exp_busy = (c != done_cyc);
      exp_brst = (c == 1);
      checks++; if (bus.in_ready !== exp_rdy) begin failures++; $display("FAIL in_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, exp_rdy); end
      checks++; if (bus.wr_en !== (bus.in_valid & exp_rdy)) begin failures++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", c, bus.wr_en, bus.in_valid & exp_rdy); end
      checks++; if (bus.buf_rst !== exp_brst) begin failures++; $display("FAIL buf_rst cyc=%0d got=%b exp=%b", c, bus.buf_rst, exp_brst); end
      checks++; if (bus.out_en !== exp_oe) begin failures++; $display("FAIL out_en cyc=%0d got=%b exp=%b", c, bus.out_en, exp_oe); end
      checks++; if (bus.done !== exp_done) begin failures++; $display("FAIL done cyc=%0d got=%b exp=%b", c, bus.done, exp_done); end
      checks++; if (bus.busy !== exp_busy) begin failures++; $display("FAIL busy cyc=%0d got=%b exp=%b", c, bus.busy, exp_busy); end
      checks++; if (bus.cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_busy cyc=%0d got=%b exp=0", c, bus.cfg_err); end
      if (bus.in_valid && exp_rdy) begin
        exp_col = DW_COL'(acc / beats);
        checks++; if (bus.col !== exp_col) begin failures++; $display("FAIL accept_col cyc=%0d beat=%0d got=%0d exp=%0d", c, acc, bus.col, exp_col); end
        acc++;
        if (acc == total) last_acc = c;
      end
      if (c == done_cyc) begin
        exp_col = DW_COL'(ncol - 1);
        checks++; if (bus.col !== exp_col) begin failures++; $display("FAIL final_col got=%0d exp=%0d", bus.col, exp_col); end
        fin = 1'b1;
      end else if (last_acc >= 0 && c > last_acc + 1 + PIPE_LAT && bus.buf_valid && rows < M) begin
        rows++;
        if (rows == M) done_cyc = c + 1;
      end
      if (abort > 0 && rows == abort) aborted = 1'b1;
      tick();
    end
    bus.start = 1'b0;
    if (!fin && !aborted) begin
      checks++; failures++;
      $display("FAIL tile_timeout ncol=%0d beats=%0d accepts=%0d rows=%0d", ncol, beats, acc, rows);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.buf_rst !== 1'b1) begin failures++; $display("FAIL reset_buf_rst got=%b exp=1", bus.buf_rst); end
    checks++; if ({bus.busy, bus.in_ready, bus.out_en, bus.done, bus.cfg_err} !== 5'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=00000", {bus.busy, bus.in_ready, bus.out_en, bus.done, bus.cfg_err}); end
    checks++; if (bus.col !== '0) begin failures++; $display("FAIL reset_col got=%0d exp=0", bus.col); end
    repeat (5) begin
      tick();
      checks++; if ({bus.buf_rst, bus.busy, bus.in_ready, bus.out_en, bus.done, bus.cfg_err} !== 6'b0) begin failures++; $display("FAIL idle_outputs got=%b exp=000000", {bus.buf_rst, bus.busy, bus.in_ready, bus.out_en, bus.done, bus.cfg_err}); end
    end
  endtask

  task automatic test_held();
    bit ab;
    run_tile(2, 3, 0, 0, 0, 0, ab);
    // buf_valid stays high after the tile completes; nothing more may fire.
    repeat (3) begin
      bus.buf_valid = 1'b1;
      #1;
      checks++; if ({bus.done, bus.busy} !== 2'b00) begin failures++; $display("FAIL post_done done_busy got=%b exp=00", {bus.done, bus.busy}); end
      tick();
    end
  endtask

  task automatic test_toggle();
    bit ab;
    run_tile(2, 3, 1, 0, 0, 0, ab);
  endtask

  task automatic test_boundary();
    bit ab;
    run_tile(16, 1, 0, 1, 0, 0, ab);
    run_tile(1, 5, 2, 1, 1, 0, ab);
  endtask

  task automatic test_cfg_err();
    int bad_ncol [3];
    int bad_beats[3];
    bad_ncol[0] = 0;  bad_beats[0] = 3;
    bad_ncol[1] = 17; bad_beats[1] = 3;
    bad_ncol[2] = 2;  bad_beats[2] = 0;
    for (int i = 0; i < 3; i++) begin
      bus.start     = 1'b1;
      bus.cfg_ncol  = (DW_COL+1)'(bad_ncol[i]);
      bus.cfg_beats = DW_BEAT'(bad_beats[i]);
      tick();
      bus.start = 1'b0;
      #1;
      checks++; if ({bus.cfg_err, bus.busy} !== 2'b10) begin failures++; $display("FAIL cfg_err_pulse case=%0d got=%b exp=10", i, {bus.cfg_err, bus.busy}); end
      tick();
      checks++; if ({bus.cfg_err, bus.busy} !== 2'b00) begin failures++; $display("FAIL cfg_err_clear case=%0d got=%b exp=00", i, {bus.cfg_err, bus.busy}); end
    end
  endtask

  task automatic test_random();
    bit ab;
    for (int t = 0; t < 20; t++)
      run_tile(int'($urandom_range(1, N)), int'($urandom_range(1, 4)),
               2, 1, 1, 0, ab);
  endtask

  task automatic test_abort();
    bit ab;
    run_tile(2, 3, 0, 0, 2, M - 1, ab);
    checks++; if (ab !== 1'b1) begin failures++; $display("FAIL abort_reach_drain got=%b exp=1", ab); end
    rst = 1'b1;
    bus.buf_valid = 1'b1;
    #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done_rst got=%b exp=0", bus.done); end
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    #1;
    checks++; if ({bus.buf_rst, bus.busy, bus.done, bus.out_en, bus.in_ready} !== 5'b10000) begin failures++; $display("FAIL abort_reset_vals got=%b exp=10000", {bus.buf_rst, bus.busy, bus.done, bus.out_en, bus.in_ready}); end
    checks++; if (bus.col !== '0) begin failures++; $display("FAIL abort_col got=%0d exp=0", bus.col); end
    repeat (4) begin
      tick();
      checks++; if ({bus.buf_rst, bus.busy, bus.done, bus.out_en} !== 4'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0000", {bus.buf_rst, bus.busy, bus.done, bus.out_en}); end
    end
    bus.buf_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_ncol = '0; bus.cfg_beats = '0;
    bus.in_valid = 1'b0; bus.buf_valid = 1'b0;
    test_reset();
    test_held();
    test_toggle();
    test_boundary();
    test_cfg_err();
    test_random();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
